// File: rtl/pipein_burst_sched_if.sv
// Burst scheduler bus: FIFO read side and SDRAM write-port side.
// The scheduler drives the master modport; FIFO/SDRAM models sit on the slave.
interface pipein_burst_sched_if #(
    parameter int ADDR_W = 24
);
    logic [7:0]        rd_data_count;
    logic              fifo_rd;
    logic [31:0]       fifo_out;
    logic              wr_req;
    logic              wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_data_valid;

    modport master (
        input  rd_data_count,
        input  fifo_out,
        input  wr_ack,
        output fifo_rd,
        output wr_req,
        output wr_addr,
        output wr_data,
        output wr_data_valid
    );

    modport slave (
        output rd_data_count,
        output fifo_out,
        output wr_ack,
        input  fifo_rd,
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        input  wr_data_valid
    );
endinterface

// File: rtl/pipein_burst_sched.sv
// Moves fixed-length bursts from an input FIFO to an SDRAM write port.
// Request/grant per burst, then BURST_LEN reads streamed one cycle later.
module pipein_burst_sched #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 24,
    parameter int MEM_WORDS = 1 << 24
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 enable,
    pipein_burst_sched_if.master bus,
    output logic                 burst_done,
    output logic [15:0]          burst_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        READ,
        DRAIN
    } state_t;

    localparam logic [6:0]      LAST_BEAT = 7'(BURST_LEN - 1);
    localparam logic [7:0]      BL_CNT    = 8'(BURST_LEN);
    localparam logic [ADDR_W:0] BL_ADDR   = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W:0] MEM_LIM   = (ADDR_W + 1)'(MEM_WORDS);

    state_t            state_q, state_d;
    logic [6:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic              start;
    logic              last_beat;
    logic [ADDR_W:0]   addr_sum;

    assign start     = enable && (bus.rd_data_count >= BL_CNT);
    assign last_beat = (beat_q == LAST_BEAT);
    assign addr_sum  = {1'b0, addr_q} + BL_ADDR;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, beat/address/count updates and strobes
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        bus.fifo_rd = 1'b0;
        bus.wr_req  = 1'b0;
        burst_done  = 1'b0;
        busy        = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.wr_req = 1'b1;
                if (bus.wr_ack) begin
                    state_d = READ;
                    beat_d  = '0;
                end
            end
            READ: begin
                bus.fifo_rd = 1'b1;
                beat_d      = beat_q + 7'd1;
                if (last_beat) begin
                    state_d = DRAIN;
                    beat_d  = '0;
                end
            end
            DRAIN: begin
                burst_done = 1'b1;
                cnt_d      = cnt_q + 16'd1;
                state_d    = IDLE;
                if (addr_sum == MEM_LIM) begin
                    addr_d = '0;
                end else begin
                    addr_d = addr_sum[ADDR_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO data lags the read strobe by one cycle
    assign vld_d = bus.fifo_rd;

    // Datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.wr_addr       = addr_q;
    assign bus.wr_data_valid = vld_q;
    assign bus.wr_data       = vld_q ? bus.fifo_out : 32'd0;
    assign burst_count       = cnt_q;

endmodule

// File: tb/tb_pipein_burst_sched.sv
// Randomized bench for pipein_burst_sched against a FIFO/SDRAM
// transaction model (word order, burst addresses, handshake rules).
module tb_pipein_burst_sched;

    localparam int BL = 8;
    localparam int AW = 24;
    localparam int MW = 32;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        enable = 1'b0;
    logic        burst_done;
    logic        busy;
    logic [15:0] burst_count;

    pipein_burst_sched_if #(.ADDR_W(AW)) bus ();

    pipein_burst_sched #(
        .BURST_LEN(BL),
        .ADDR_W   (AW),
        .MEM_WORDS(MW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .enable     (enable),
        .bus        (bus),
        .burst_done (burst_done),
        .burst_count(burst_count),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] seq;
    logic [AW-1:0] req_addr;

    int nb;
    int rd_cnt;
    int vld_cnt;
    int req_len;
    int ack_delay;
    int cyc;
    int last_start;
    int req_rises;
    int cnt_prev;
    bit req_prev;
    bit prev_ok;
    bit busy_prev;
    bit en_prev;
    bit rand_mode;
    bit hold_mode;
    bit fast_mode;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_addr();
        return 64'((nb * BL) % MW);
    endfunction

    task automatic upd_cnt();
        if (fifo_q.size() > 255) bus.rd_data_count = 8'd255;
        else bus.rd_data_count = 8'(fifo_q.size());
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        upd_cnt();
    endtask

    task automatic tick();
        logic          s_rd, s_req, s_vld, s_done, s_busy;
        logic [AW-1:0] s_addr;
        logic [31:0]   s_data;
        logic [15:0]   s_cnt;
        logic [31:0]   w;
        en_prev  = enable;
        cnt_prev = int'(bus.rd_data_count);
        @(negedge CLK);
        cyc++;
        s_rd   = bus.fifo_rd;
        s_req  = bus.wr_req;
        s_vld  = bus.wr_data_valid;
        s_done = burst_done;
        s_busy = busy;
        s_addr = bus.wr_addr;
        s_data = bus.wr_data;
        s_cnt  = burst_count;

        check("burst_count", s_cnt, 64'(nb % 65536));
        if (prev_ok && !busy_prev)
            check("start_rule", s_busy, en_prev && (cnt_prev >= BL));
        if (!s_busy) begin
            check("idle_addr", s_addr, exp_addr());
            check("idle_strobes", {s_rd, s_req, s_vld, s_done}, 0);
        end

        if (s_req) begin
            if (!req_prev) begin
                req_rises++;
                check("req_addr", s_addr, exp_addr());
                if (fast_mode && last_start >= 0)
                    check("burst_period", cyc - last_start, BL + 3);
                last_start = cyc;
                req_len = 0;
                req_addr = s_addr;
                if (rand_mode) ack_delay = $urandom_range(0, 3);
            end else begin
                check("addr_stable", s_addr, req_addr);
            end
            req_len++;
        end else if (req_prev) begin
            check("req_len", req_len, ack_delay + 1);
        end

        if (s_rd) begin
            check("rd_nonempty", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                bus.fifo_out = w;
            end
            rd_cnt++;
        end

        if (s_vld) begin
            if (exp_q.size() > 0) w = exp_q.pop_front();
            else w = 'x;
            check("wr_data", s_data, w);
            vld_cnt++;
        end

        if (s_done) begin
            check("drain_beat", s_vld, 1);
            check("rd_beats", rd_cnt, BL);
            check("vld_beats", vld_cnt, BL);
            nb++;
            rd_cnt = 0;
            vld_cnt = 0;
        end

        if (s_req && req_len == ack_delay + 1) bus.wr_ack = 1'b1;
        else if (rand_mode && !s_req) bus.wr_ack = ($urandom_range(0, 3) == 0);
        else bus.wr_ack = 1'b0;

        if (rand_mode) begin
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 240) push($urandom);
        end
        if (hold_mode) begin
            while (fifo_q.size() < 200) begin
                push(seq);
                seq++;
            end
        end
        upd_cnt();

        prev_ok   = 1'b1;
        busy_prev = s_busy;
        req_prev  = s_req;
    endtask

    task automatic wait_bursts(input int n, input int max_cyc);
        int tgt;
        tgt = nb + n;
        for (int i = 0; i < max_cyc && nb < tgt; i++) tick();
        check("bursts_done", nb >= tgt, 1);
    endtask

    initial begin
        bus.wr_ack = 1'b0;
        bus.fifo_out = '0;
        bus.rd_data_count = '0;
        nb = 0; rd_cnt = 0; vld_cnt = 0; req_len = 0; cyc = 0;
        ack_delay = 0; last_start = -1; req_rises = 0; seq = 0;
        req_prev = 0; prev_ok = 0; busy_prev = 0; en_prev = 0;
        rand_mode = 0; hold_mode = 0; fast_mode = 0; req_addr = '0;

        repeat (2) @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_wr_req", bus.wr_req, 0);
        check("rst_fifo_rd", bus.fifo_rd, 0);
        check("rst_valid", bus.wr_data_valid, 0);
        check("rst_done", burst_done, 0);
        check("rst_count", burst_count, 0);
        check("rst_addr", bus.wr_addr, 0);
        RST_N = 1'b1;

        // seven words never satisfy an eight-word burst
        for (int i = 0; i < 7; i++) begin
            push(seq);
            seq++;
        end
        enable = 1'b1;
        req_rises = 0;
        repeat (30) tick();
        check("no_req_7", req_rises, 0);

        // twelve words, grant on the third request cycle
        ack_delay = 2;
        for (int i = 0; i < 5; i++) begin
            push(seq);
            seq++;
        end
        wait_bursts(1, 200);
        tick();
        check("count_after_1", burst_count, 1);
        check("addr_after_1", bus.wr_addr, 8);

        // level held high, immediate grants, wrap at 32 words
        ack_delay = 0;
        hold_mode = 1;
        fast_mode = 1;
        last_start = -1;
        wait_bursts(5, 400);
        enable = 1'b0;
        hold_mode = 0;
        fast_mode = 0;
        repeat (4) tick();
        check("wrap_addr", bus.wr_addr, 16);
        check("count_after_6", burst_count, 6);

        // enable dropped while the request is pending
        ack_delay = 4;
        enable = 1'b1;
        for (int i = 0; i < 20 && !req_prev; i++) tick();
        check("req_seen", req_prev, 1);
        enable = 1'b0;
        wait_bursts(1, 100);
        req_rises = 0;
        repeat (40) tick();
        check("no_req_disabled", req_rises, 0);

        // random traffic
        rand_mode = 1;
        repeat (800) tick();
        rand_mode = 0;
        enable = 1'b0;
        for (int i = 0; i < 100 && busy_prev; i++) tick();
        repeat (2) tick();
        check("rand_idle", busy, 0);

        // reset in the middle of the read phase
        for (int i = 0; i < 16; i++) push($urandom);
        ack_delay = 1;
        enable = 1'b1;
        for (int i = 0; i < 100 && rd_cnt < 4; i++) tick();
        check("reached_beat4", rd_cnt, 4);
        #3 RST_N = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_fifo_rd", bus.fifo_rd, 0);
        check("arst_wr_req", bus.wr_req, 0);
        check("arst_valid", bus.wr_data_valid, 0);
        check("arst_done", burst_done, 0);
        check("arst_count", burst_count, 0);
        check("arst_addr", bus.wr_addr, 0);
        fifo_q.delete();
        exp_q.delete();
        nb = 0; rd_cnt = 0; vld_cnt = 0;
        req_prev = 0; prev_ok = 0; busy_prev = 0;
        bus.wr_ack = 1'b0;
        upd_cnt();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) push($urandom);
        wait_bursts(1, 100);
        tick();
        check("post_rst_count", burst_count, 1);
        check("post_rst_addr", bus.wr_addr, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipein_burst_sched.md
PIPEIN_BURST_SCHED -- requirements
Module: pipein_burst_sched

Interface
REQ-001 Parameter BURST_LEN, default 8, SHALL set the number of 32-bit words per SDRAM write burst (legal 1..64).
REQ-002 Parameter ADDR_W, default 24, SHALL set the width of the word address toward the SDRAM write port.
REQ-003 Parameter MEM_WORDS, default 2^24, SHALL set the size of the write region in words; it is a multiple of BURST_LEN.
REQ-004 CLK  in  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-005 RST_N  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 enable  in  1  SHALL be level: 1 = new bursts allowed.
REQ-007 rd_data_count  in  8  SHALL be the FIFO word count.
REQ-008 fifo_rd  out  1  SHALL be the FIFO read strobe, one word per high cycle.
REQ-009 fifo_out  in  32  SHALL be the FIFO data, valid the cycle after fifo_rd.
REQ-010 wr_req  out  1  SHALL be the burst request to the SDRAM controller.
REQ-011 wr_ack  in  1  SHALL be the one-cycle grant of wr_req.
REQ-012 wr_addr  out  ADDR_W  SHALL be the start word address of the requested burst.
REQ-013 wr_data  out  32  SHALL be the burst write data.
REQ-014 wr_data_valid  out  1  SHALL qualify wr_data; the sink accepts every valid cycle (no backpressure).
REQ-015 burst_done  out  1  SHALL be a one-cycle pulse at burst completion.
REQ-016 burst_count  out  16  SHALL be the number of completed bursts, wrapping modulo 2^16.
REQ-017 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, READ, DRAIN.
REQ-019 IDLE -> REQ SHALL occur when enable=1 and rd_data_count >= BURST_LEN; this is sampled only in IDLE.
REQ-020 In REQ, wr_req SHALL be 1 and wr_addr stable; wr_req SHALL NOT be withdrawn before wr_ack, even if enable falls.
REQ-021 REQ -> READ SHALL occur on the cycle wr_ack=1; wr_ack in any other state SHALL be ignored.
REQ-022 In READ, fifo_rd SHALL be 1 for exactly BURST_LEN consecutive cycles, counted by a beat counter; the last beat SHALL transition to DRAIN.
REQ-023 wr_data_valid SHALL be fifo_rd delayed by one cycle, and wr_data SHALL equal fifo_out in that cycle; this gives exactly BURST_LEN valid beats in order.
REQ-024 DRAIN SHALL last one cycle and carry the final valid beat.
REQ-025 In DRAIN, burst_done SHALL be 1, burst_count SHALL increment, and wr_addr SHALL advance by BURST_LEN.
REQ-026 DRAIN -> IDLE SHALL be unconditional.
REQ-027 Address wrap: if wr_addr + BURST_LEN = MEM_WORDS, the next wr_addr SHALL be 0; the address arithmetic is ADDR_W+1 bits wide, with no carry into the output.
REQ-028 fifo_rd SHALL NOT be asserted outside READ; the FIFO is never read when empty, because the count was checked in IDLE and the FIFO is the only consumer.
REQ-029 If enable is low in IDLE, the block SHALL stay in IDLE with all strobes low; an in-flight burst always completes.
REQ-030 The minimum gap between bursts SHALL be 1 IDLE cycle; back-to-back bursts with wr_ack immediate SHALL take BURST_LEN+3 cycles each.

Reset
REQ-031 RST_N low SHALL immediately, regardless of CLK, force state=IDLE, beat counter=0, wr_addr=0, burst_count=0, and fifo_rd, wr_req, wr_data_valid, burst_done and busy to 0; wr_data=0 is don't-care.
REQ-032 Reset mid-burst SHALL abandon the burst without completing it; after RST_N rises, the first request SHALL be at wr_addr=0.

Verification
REQ-033 Count 7, BURST_LEN 8, enable 1 -> wr_req stays 0 and fifo_rd stays 0 indefinitely.
REQ-034 Count 12, wr_ack 3 cycles after wr_req, FIFO data 0..11 -> wr_req held 3 cycles, then 8 fifo_rd cycles, then wr_data 0..7 on 8 valid cycles; burst_done once; burst_count=1; wr_addr=8.
REQ-035 Count held at 200 with immediate acks, 4 bursts -> addresses 0, 8, 16, 24; each burst spans 11 cycles; burst_count=4.
REQ-036 MEM_WORDS=32, 5 bursts -> wr_addr sequence 0, 8, 16, 24, 0.
REQ-037 enable dropped during REQ -> burst still completes on ack; no further wr_req until enable=1 again.
REQ-038 RST_N pulsed low in the middle of READ (beat 4) -> outputs zero asynchronously; the next burst requests at address 0 with burst_count=0.
